rx_iq_packer: RTL and testbench
===============================

Name: rx_iq_packer

Overview:
- Sits directly downstream of the receiver chain and consumes its 24-bit I/Q samples on each output strobe.
- Buffers the samples in a sample FIFO.
- Serialises each sample into six bytes, MSB first, for the Ethernet/USB frame builder.
- The byte side uses a valid/ready handshake and carries frame-start and frame-end markers.
- Counts samples dropped on overflow.

Parameters:
DEPTH, 64, sample FIFO depth in 48-bit words; power of 2, 4..1024
SAMPLES_PER_FRAME, 63, samples per output frame; 1..1023
OVF_WIDTH, 16, width of the overflow counter

Ports:
clock  in  1  system clock (122.88 MHz); all logic on its rising edge
reset  in  1  synchronous, active-high reset
in_strobe  in  1  one-cycle pulse; in_I/in_Q valid
in_I  in  24  signed I sample from receiver
in_Q  in  24  signed Q sample from receiver
out_data  out  8  current byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte when out_valid && out_ready
out_sof  out  1  qualifies out_data as byte 0 of sample 0 of a frame
out_eof  out  1  qualifies out_data as byte 5 of sample SAMPLES_PER_FRAME-1
fill_level  out  clog2(DEPTH)+1  words currently in FIFO (excludes serialiser word)
overflow_count  out  OVF_WIDTH  dropped-sample count, saturating

Behaviour:
- Reset:
  - out_valid, out_sof, out_eof, out_data, fill_level and overflow_count are all 0.
  - FIFO pointers are 0.
  - Serialiser state is IDLE; byte index and sample index are 0.
  - Reset mid-frame discards the FIFO contents and the partially sent sample. The next byte emitted carries out_sof.
- FIFO write: on in_strobe, word {in_I,in_Q} is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow_count increments, holding at all-ones.
  - overflow_count is cleared only by reset.
- fill_level is registered. It is +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
- Serialiser FSM, two states:
  - IDLE: out_valid=0. If fill_level>0, pop a word into a 48-bit holding register, set byte index to 0 and go to SEND.
  - SEND: out_valid=1. out_data = holding[47-8*b -: 8] for byte index b=0..5. Order: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
  - A transfer (out_valid && out_ready) on b<5 increments b.
  - A transfer on b=5 increments the sample index. The sample index wraps from SAMPLES_PER_FRAME-1 to 0.
  - After the b=5 transfer: if fill_level>0, pop and load the next word in the same cycle and stay in SEND with b=0 (no bubble). Otherwise go to IDLE.
  - Without a transfer, out_data, out_sof and out_eof hold stable.
- out_sof = (SEND && b==0 && sample index==0).
- out_eof = (SEND && b==5 && sample index==SAMPLES_PER_FRAME-1).
- With SAMPLES_PER_FRAME=1, both flags appear within every sample.
- Latency:
  - in_strobe at cycle N into an empty FIFO with the serialiser IDLE gives fill_level=1 at N+1.
  - The pop occurs in cycle N+1.
  - out_valid=1 with byte 0 at N+2.
- Throughput: with out_ready held high, 6 clocks per sample.
  - The upstream strobe rate must average at least 6 clocks per sample; 960 kHz at 122.88 MHz is 128 clocks per sample.
- Storage capacity is DEPTH words plus one word in the serialiser.

Test Plan:
1. Reset, out_ready=1, one strobe with I=0x123456, Q=0xABCDEF at cycle 0 -> bytes 12,34,56,AB,CD,EF on cycles 2..7. out_sof=1 on byte 12 only; out_eof=0 (SAMPLES_PER_FRAME=63); out_valid=0 at cycle 8.
2. Same sample with out_ready toggled 1,0,0,1,... -> each byte held unchanged while out_ready=0. The byte sequence is identical to test 1 and no byte is duplicated or skipped.
3. 126 strobes at 128-clock spacing, out_ready=1 -> 756 bytes. out_eof on bytes 378 and 756, out_sof on bytes 1 and 379, no other flags. fill_level never exceeds 1.
4. DEPTH=64, out_ready=0, 70 strobes 2 clocks apart -> 1 word in the serialiser, fill_level=64, overflow_count=5. Then out_ready=1 -> exactly 65 samples (390 bytes) out, in order.
5. FIFO full (fill_level=64); assert in_strobe in the same cycle as the b=5 transfer -> sample accepted, overflow_count unchanged, fill_level stays 64.
6. Reset asserted for one cycle during byte 3 of sample 10 with 5 words queued -> fill_level=0 and out_valid=0 next cycle. The next strobe produces its byte 0 with out_sof=1 two cycles later; overflow_count=0.

Source files
------------

// File: rtl/rx_iq_packer.sv
// rx_iq_packer: buffers 24-bit I/Q receiver samples in a FIFO and
// serialises each one as six bytes (I MSB first, then Q) onto a
// valid/ready byte stream with frame start/end markers.
// Ports: clock, reset (sync, active-high); in_strobe/in_I/in_Q sample
// input; out_data/out_valid/out_ready/out_sof/out_eof byte stream;
// fill_level (FIFO words, excl. serialiser); overflow_count (saturating).
module rx_iq_packer #(
  parameter int DEPTH             = 64,
  parameter int SAMPLES_PER_FRAME = 63,
  parameter int OVF_WIDTH         = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_strobe,
  input  logic [23:0]              in_I,
  input  logic [23:0]              in_Q,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [OVF_WIDTH-1:0]     overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW =
    (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(SAMPLES_PER_FRAME - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [47:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fill_q, fill_d;
  logic [47:0]     hold_q, hold_d;
  logic [2:0]      b_q, b_d;
  logic [SW-1:0]   sidx_q, sidx_d;
  logic [OVF_WIDTH-1:0] ovf_q;

  logic xfer, pop, push, drop, full, avail;

  assign full  = (fill_q == FULL);
  assign avail = (fill_q != '0);
  assign xfer  = (state_q == SEND) && out_ready;
  // A full FIFO still accepts a word when the serialiser pops this cycle.
  assign push  = in_strobe && (!full || pop);
  assign drop  = in_strobe && !push;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    b_d     = b_q;
    sidx_d  = sidx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          pop     = 1'b1;
          hold_d  = mem[rd_ptr_q];
          b_d     = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (b_q != 3'd5) begin
            b_d = b_q + 3'd1;
          end else begin
            b_d    = 3'd0;
            sidx_d = (sidx_q == LAST) ? '0 : sidx_q + 1'b1;
            // Back-to-back reload avoids a bubble between samples.
            if (avail) begin
              pop    = 1'b1;
              hold_d = mem[rd_ptr_q];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {in_I, in_Q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      hold_q   <= '0;
      b_q      <= '0;
      sidx_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      b_q     <= b_d;
      sidx_q  <= sidx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == SEND) begin
      unique case (b_q)
        3'd0:    out_data = hold_q[47:40];
        3'd1:    out_data = hold_q[39:32];
        3'd2:    out_data = hold_q[31:24];
        3'd3:    out_data = hold_q[23:16];
        3'd4:    out_data = hold_q[15:8];
        3'd5:    out_data = hold_q[7:0];
        default: out_data = '0;
      endcase
    end
  end

  assign out_valid      = (state_q == SEND);
  assign out_sof        = out_valid && (b_q == 3'd0) && (sidx_q == '0);
  assign out_eof        = out_valid && (b_q == 3'd5) && (sidx_q == LAST);
  assign fill_level     = fill_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_rx_iq_packer.sv
// tb_rx_iq_packer: table vectors, directed corner sequences and random
// traffic against a byte-queue reference model of rx_iq_packer.
module tb_rx_iq_packer;

  localparam int DEPTH = 64;
  localparam int SPF   = 63;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_strobe;
  logic [23:0] in_I, in_Q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof, out_eof;
  logic [6:0]  fill_level;
  logic [15:0] overflow_count;

  rx_iq_packer #(
    .DEPTH(DEPTH),
    .SAMPLES_PER_FRAME(SPF),
    .OVF_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_strobe(in_strobe),
    .in_I(in_I),
    .in_Q(in_Q),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof(out_sof),
    .out_eof(out_eof),
    .fill_level(fill_level),
    .overflow_count(overflow_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } byte_t;

  typedef struct {
    logic        strobe;
    logic [23:0] i;
    logic [23:0] q;
    logic        ready;
    logic        ev;
    logic [7:0]  ed;
    logic        es;
    logic        ee;
    int          ef;
  } vec_t;

  byte_t exp_q[$];
  int    msidx;
  int    checks = 0;
  int    errors = 0;
  int    max_fill, sof_cnt, eof_cnt;
  logic  prev_hold;
  logic [7:0] prev_d;
  logic  prev_s, prev_e;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference: every accepted sample becomes six bytes, MSB first,
  // flagged by its position in the running frame count.
  task automatic push_sample(input logic [23:0] i, input logic [23:0] q);
    logic [47:0] w;
    byte_t       b;
    w = {i, q};
    for (int k = 0; k < 6; k++) begin
      b.d = w[47-8*k -: 8];
      b.s = (k == 0) && (msidx == 0);
      b.e = (k == 5) && (msidx == SPF - 1);
      exp_q.push_back(b);
    end
    msidx = (msidx + 1) % SPF;
  endtask

  task automatic monitor();
    byte_t e;
    if (reset) begin
      prev_hold = 1'b0;
      return;
    end
    if (prev_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_d);
      check("hold_sof", out_sof, prev_s);
      check("hold_eof", out_eof, prev_e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("byte_data", out_data, e.d);
        check("byte_sof", out_sof, e.s);
        check("byte_eof", out_eof, e.e);
        if (out_sof) sof_cnt++;
        if (out_eof) eof_cnt++;
      end
    end
    if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    prev_hold = out_valid && !out_ready;
    prev_d    = out_data;
    prev_s    = out_sof;
    prev_e    = out_eof;
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_strobe = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    msidx = 0;
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eof", out_eof, 0);
    check("rst_data", out_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_ovf", overflow_count, 0);
    reset = 1'b0;
  endtask

  task automatic send(input logic [23:0] i, input logic [23:0] q,
                      input bit accept);
    in_I      = i;
    in_Q      = q;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    if (accept) push_sample(i, q);
  endtask

  // mode 0: ready high; 1: pattern 1,0,0; 2: random 3/4 high
  task automatic drain(input string name, input int budget,
                       input int mode);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      n++;
    end
    if (exp_q.size() > 0) check({name, "_timeout"}, exp_q.size(), 0);
    check({name, "_idle"}, out_valid, 0);
    check({name, "_fill"}, fill_level, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[8];
    logic [23:0] ri, rq;
    tv[0] = '{1, 24'h123456, 24'hABCDEF, 1, 0, 8'h00, 0, 0, 1};
    tv[1] = '{0, 24'h0, 24'h0, 1, 1, 8'h12, 1, 0, 0};
    tv[2] = '{0, 24'h0, 24'h0, 1, 1, 8'h34, 0, 0, 0};
    tv[3] = '{0, 24'h0, 24'h0, 1, 1, 8'h56, 0, 0, 0};
    tv[4] = '{0, 24'h0, 24'h0, 1, 1, 8'hAB, 0, 0, 0};
    tv[5] = '{0, 24'h0, 24'h0, 1, 1, 8'hCD, 0, 0, 0};
    tv[6] = '{0, 24'h0, 24'h0, 1, 1, 8'hEF, 0, 0, 0};
    tv[7] = '{0, 24'h0, 24'h0, 1, 0, 8'h00, 0, 0, 0};

    in_I = '0;
    in_Q = '0;
    prev_hold = 1'b0;
    max_fill = 0;
    sof_cnt = 0;
    eof_cnt = 0;
    do_reset();

    // 1: single sample, latency and byte order
    push_sample(24'h123456, 24'hABCDEF);
    for (int r = 0; r < 8; r++) begin
      in_strobe = tv[r].strobe;
      in_I      = tv[r].i;
      in_Q      = tv[r].q;
      out_ready = tv[r].ready;
      tick();
      in_strobe = 1'b0;
      check($sformatf("t1_valid[%0d]", r), out_valid, tv[r].ev);
      if (tv[r].ev) begin
        check($sformatf("t1_data[%0d]", r), out_data, tv[r].ed);
        check($sformatf("t1_sof[%0d]", r), out_sof, tv[r].es);
        check($sformatf("t1_eof[%0d]", r), out_eof, tv[r].ee);
      end
      check($sformatf("t1_fill[%0d]", r), fill_level, tv[r].ef);
    end

    // 2: backpressure pattern
    do_reset();
    out_ready = 1'b1;
    send(24'h123456, 24'hABCDEF, 1);
    drain("t2", 60, 1);

    // 3: two full frames at the nominal strobe rate
    do_reset();
    out_ready = 1'b1;
    max_fill = 0;
    sof_cnt = 0;
    eof_cnt = 0;
    for (int s = 0; s < 126; s++) begin
      send(24'($urandom), 24'($urandom), 1);
      for (int k = 0; k < 127; k++) tick();
    end
    drain("t3", 20, 0);
    check("t3_sof_count", sof_cnt, 2);
    check("t3_eof_count", eof_cnt, 2);
    check("t3_max_fill_le1", max_fill <= 1, 1);

    // 4: overflow with stalled consumer, then drain in order
    do_reset();
    for (int s = 0; s < 70; s++) begin
      send(24'($urandom), 24'($urandom), s < DEPTH + 1);
      tick();
    end
    check("t4_fill", fill_level, DEPTH);
    check("t4_ovf", overflow_count, 5);
    drain("t4", 600, 0);
    check("t4_ovf_kept", overflow_count, 5);

    // 5: write into a full FIFO on the same cycle as the final-byte pop
    do_reset();
    for (int s = 0; s < DEPTH + 1; s++) begin
      send(24'($urandom), 24'($urandom), 1);
      tick();
    end
    check("t5_fill_full", fill_level, DEPTH);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    ri = 24'($urandom);
    rq = 24'($urandom);
    send(ri, rq, 1);
    check("t5_ovf", overflow_count, 0);
    check("t5_fill", fill_level, DEPTH);
    drain("t5", 700, 0);

    // 6: reset mid-frame with words queued
    do_reset();
    for (int s = 0; s < 16; s++) begin
      send(24'($urandom), 24'($urandom), 1);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 63; k++) tick();
    check("t6_pre_fill", fill_level, 5);
    out_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    msidx = 0;
    tick();
    reset = 1'b0;
    check("t6_fill", fill_level, 0);
    check("t6_valid", out_valid, 0);
    check("t6_ovf", overflow_count, 0);
    ri = 24'($urandom);
    rq = 24'($urandom);
    send(ri, rq, 1);
    tick();
    check("t6_new_valid", out_valid, 1);
    check("t6_new_sof", out_sof, 1);
    check("t6_new_data", out_data, ri[23:16]);
    drain("t6", 40, 0);

    // random traffic with random backpressure
    do_reset();
    for (int s = 0; s < 300; s++) begin
      send(24'($urandom), 24'($urandom), 1);
      for (int k = 0; k < int'($urandom_range(8, 20)); k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    drain("rand", 5000, 2);
    check("rand_ovf", overflow_count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
